// File: rtl/home_pkg.sv
// Shared constants for the home event scheduler: display codes, FSM states, sensor indices.
package home_pkg;

  localparam int unsigned N_SENS = 4;

  localparam logic [2:0] DISP_IDLE  = 3'b000;
  localparam logic [2:0] DISP_FDOOR = 3'b001;
  localparam logic [2:0] DISP_RDOOR = 3'b010;
  localparam logic [2:0] DISP_ALARM = 3'b011;
  localparam logic [2:0] DISP_WIN   = 3'b100;

  localparam logic [1:0] IDX_FD  = 2'd0;
  localparam logic [1:0] IDX_RD  = 2'd1;
  localparam logic [1:0] IDX_WIN = 2'd2;
  localparam logic [1:0] IDX_FA  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One-hot actuator vector for a sensor index.
  function automatic logic [N_SENS-1:0] idx_onehot(input logic [1:0] idx);
    return N_SENS'(1) << idx;
  endfunction

  // Display code shown while a sensor index is being served.
  function automatic logic [2:0] disp_code(input logic [1:0] idx);
    case (idx)
      IDX_FD:  return DISP_FDOOR;
      IDX_RD:  return DISP_RDOOR;
      IDX_WIN: return DISP_WIN;
      default: return DISP_ALARM;
    endcase
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one binary sensor.
module sensor_debounce #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic Rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CW = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // Level flips on the DEB_CYC-th consecutive differing sample; a mismatch-free sample restarts the count.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEB_CYC - 1)) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/home_event_scheduler.sv
// Debounces the sensors, grants one actuator at a time by fixed priority with fire preemption,
// and runs heater/cooler hysteresis on the temperature input.
module home_event_scheduler
  import home_pkg::*;
#(
  parameter int unsigned DEB_CYC  = 4,
  parameter int unsigned HOLD_CYC = 8,
  parameter logic [6:0]  T_LOW    = 7'd18,
  parameter logic [6:0]  T_HIGH   = 7'd30,
  parameter logic [6:0]  HYST     = 7'd2
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SW,
  input  logic       SFA,
  input  logic [6:0] ST,
  output logic       fdoor,
  output logic       rdoor,
  output logic       winbuzz,
  output logic       alarmbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic       busy
);

  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [N_SENS-1:0] w_pin;
  logic [N_SENS-1:0] w_level;
  logic [N_SENS-1:0] w_rise;
  logic [N_SENS-1:0] w_req;
  logic [1:0]        w_sel;
  logic              w_any;
  logic              w_alarm_next;
  logic              w_unused_levels;

  state_t            r_state;
  logic [1:0]        r_grant;
  logic [HW-1:0]     r_cnt;
  logic [N_SENS-1:0] r_pend;
  logic [N_SENS-1:0] r_act;
  logic [2:0]        r_disp;
  logic              r_busy;

  logic       r_heater;
  logic       r_cooler;
  logic       r_alarm_d;
  logic       w_heat;
  logic       w_cool;
  logic       w_force_off;
  logic [7:0] w_st8;
  logic [7:0] w_lo_on;
  logic [7:0] w_lo_off;
  logic [7:0] w_hi_on;
  logic [7:0] w_hi_off;

  assign w_pin = {SFA, SW, SRD, SFD};

  genvar g;
  generate
    for (g = 0; g < N_SENS; g++) begin : g_deb
      sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk     (clk),
        .Rst     (Rst),
        .i_pin   (w_pin[g]),
        .o_level (w_level[g]),
        .o_rise  (w_rise[g])
      );
    end
  endgenerate

  // Only the fire level gates the grant; the other debounced levels are consumed via their edges.
  assign w_unused_levels = ^w_level[2:0];

  // Requests include edges arriving this cycle so a fresh event is granted without an extra cycle.
  assign w_req = r_pend | w_rise;
  assign w_any = |w_req;

  // Fixed priority select: fire, window, rear door, front door.
  always_comb begin
    w_sel = IDX_FD;
    if (w_req[IDX_FA])       w_sel = IDX_FA;
    else if (w_req[IDX_WIN]) w_sel = IDX_WIN;
    else if (w_req[IDX_RD])  w_sel = IDX_RD;
    else                     w_sel = IDX_FD;
  end

  // Grant sequencing with registered actuator, display and busy outputs.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_grant <= IDX_FD;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_act   <= '0;
      r_disp  <= DISP_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_pend <= w_req;
      case (r_state)
        IDLE: begin
          r_act  <= '0;
          r_disp <= DISP_IDLE;
          r_busy <= 1'b0;
          if (w_any) begin
            r_grant <= w_sel;
            r_cnt   <= HW'(HOLD_CYC - 1);
            r_pend  <= w_req & ~idx_onehot(w_sel);
            r_act   <= idx_onehot(w_sel);
            r_disp  <= disp_code(w_sel);
            r_busy  <= 1'b1;
            r_state <= SERVE;
          end
        end
        SERVE: begin
          if ((r_grant != IDX_FA) && w_req[IDX_FA]) begin
            // Fire takes over; the interrupted event goes back to pending.
            r_grant <= IDX_FA;
            r_cnt   <= HW'(HOLD_CYC - 1);
            r_pend  <= (w_req & ~idx_onehot(IDX_FA)) | idx_onehot(r_grant);
            r_act   <= idx_onehot(IDX_FA);
            r_disp  <= DISP_ALARM;
          end else if (r_cnt == '0) begin
            // Fire grant saturates at zero until the debounced alarm drops.
            if ((r_grant != IDX_FA) || !w_level[IDX_FA]) begin
              r_act   <= '0;
              r_disp  <= DISP_IDLE;
              r_busy  <= 1'b0;
              r_state <= GAP;
            end
          end else begin
            r_cnt <= r_cnt - HW'(1);
          end
        end
        GAP: begin
          r_act   <= '0;
          r_disp  <= DISP_IDLE;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_act   <= '0;
          r_disp  <= DISP_IDLE;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Next-cycle value of the fire buzzer so climate outputs drop together with it.
  always_comb begin
    w_alarm_next = 1'b0;
    case (r_state)
      IDLE:  w_alarm_next = w_any && (w_sel == IDX_FA);
      SERVE: begin
        if (r_grant != IDX_FA) w_alarm_next = w_req[IDX_FA];
        else                   w_alarm_next = !((r_cnt == '0) && !w_level[IDX_FA]);
      end
      default: w_alarm_next = 1'b0;
    endcase
  end

  assign w_st8    = {1'b0, ST};
  assign w_lo_on  = 8'(T_LOW);
  assign w_lo_off = 8'(T_LOW) + 8'(HYST);
  assign w_hi_on  = 8'(T_HIGH);
  assign w_hi_off = 8'(T_HIGH) - 8'(HYST);

  // Hysteresis decisions; heater wins if both would be on.
  always_comb begin
    w_heat = r_heater;
    w_cool = r_cooler;
    if (w_st8 < w_lo_on)        w_heat = 1'b1;
    else if (w_st8 >= w_lo_off) w_heat = 1'b0;
    if (w_st8 > w_hi_on)        w_cool = 1'b1;
    else if (w_st8 <= w_hi_off) w_cool = 1'b0;
    if (w_heat)                 w_cool = 1'b0;
  end

  // Climate is held off during the fire buzzer and for one cycle after it ends.
  assign w_force_off = w_alarm_next | r_act[IDX_FA] | r_alarm_d;

  // Climate register pair, updated every cycle.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_heater  <= 1'b0;
      r_cooler  <= 1'b0;
      r_alarm_d <= 1'b0;
    end else begin
      r_alarm_d <= r_act[IDX_FA];
      r_heater  <= w_force_off ? 1'b0 : w_heat;
      r_cooler  <= w_force_off ? 1'b0 : w_cool;
    end
  end

  assign fdoor     = r_act[IDX_FD];
  assign rdoor     = r_act[IDX_RD];
  assign winbuzz   = r_act[IDX_WIN];
  assign alarmbuzz = r_act[IDX_FA];
  assign heater    = r_heater;
  assign cooler    = r_cooler;
  assign display   = r_disp;
  assign busy      = r_busy;

endmodule
